ro_freq_meter: RTL
==================

// Module: ro_freq_meter
// PURPOSE
//  Reader for the ring-oscillator output: measures RO frequency as rising edges counted in a clk-timed gate.
//  Drives RO enable only during measurement; returns count via valid/ready handshake; sits beside RO in tt_um top.
//  Single clk domain: osc_in asynchronous, synchronized, edge-detected; valid for f_osc < f_clk/2.
// PARAMETERS
//  CNT_W        16  edge-counter / result width
//  GATE_W       20  gate-length width (clk cycles)
//  SYNC_STAGES  2   synchronizer flops on osc_in (>=2)
// PORTS
//  clk           in   1       system clock, all logic rising-edge
//  rst_n         in   1       asynchronous active-low reset
//  osc_in        in   1       raw RO output, asynchronous
//  start         in   1       level/pulse; sampled only in IDLE
//  gate_cycles   in   GATE_W  gate length, latched when start accepted
//  ro_en         out  1       RO enable
//  busy          out  1       high in ARM, GATE, DONE
//  result_valid  out  1       result held and valid
//  result_ready  in   1       consumer accepts result
//  result_count  out  CNT_W   edges counted in gate
//  overflow      out  1       count exceeded 2^CNT_W-1 during gate
// BEHAVIOUR
//  Reset: state IDLE; ro_en=0, busy=0, result_valid=0, result_count=0, overflow=0; sync chain, counters 0.
//  FSM IDLE->ARM->GATE->DONE->IDLE:
//   IDLE: start=1 -> latch gate_cycles, clear count/overflow, ro_en=1 next cycle, go ARM.
//   ARM: SYNC_STAGES+1 cycles flushing synchronizer; edges discarded; -> GATE (latched gate 0 -> DONE, count 0).
//   GATE: exactly latched gate_cycles cycles; edge = synced & ~prev counts +1 per cycle; -> DONE.
//   DONE: result_valid=1, count/overflow stable; valid&&ready -> IDLE same edge; ro_en, busy, valid low next cycle.
//  ro_en high ARM..DONE inclusive; start outside IDLE ignored (no queueing).
//  start in IDLE: busy asserted first edge after; start=1 in cycle after DONE->IDLE begins new run.
//  result_count registered; changes only in GATE, cleared on start acceptance; held in IDLE after handshake.
//  Max latency start->valid: 1 + (SYNC_STAGES+1) + gate_cycles cycles.
//  Accuracy: +/-1 edge (gate-boundary quantization); osc at/above f_clk/2 undercounts (aliasing), not flagged.
//  rst_n low mid-run: immediate return to reset values, ro_en drops asynchronously.
// CONFIGURATION
//  RO_METER_SAT_EN defined: counter saturates at 2^CNT_W-1, overflow=1 on first extra edge.
//  Undefined: counter wraps mod 2^CNT_W, overflow=1 (sticky to next start) on first wrap.
// STRUCTURE
//  ro_meter_pkg: state enum typedef (IDLE, ARM, GATE, DONE), ARM_CYCLES = SYNC_STAGES+1 constant.
//  Sub-module ro_sync_edge: SYNC_STAGES flop chain + prev flop, outputs 1-cycle rise pulse; reset to 0.
//  Top holds FSM, gate down-counter, edge counter, output regs.
// TESTING
//  osc = clk/4 phase-locked, gate_cycles=100 -> result_count 25 (+/-1), overflow=0, ro_en high throughout.
//  osc=clk/2, gate_cycles=200000 -> SAT_EN: count 65535 overflow=1; else 34464 (+/-1) overflow=1.
//  gate_cycles=0, start -> valid after ARM, count 0; result_ready low 50 cycles -> count, valid stable.
//  start pulsed during GATE and DONE -> ignored; only one result; second start after handshake measures again.
//  rst_n low mid-GATE -> ro_en, busy, valid, count 0 at once; next run correct.
//  osc_in static -> count 0; edges during ARM flush not counted (glitch at ARM start -> 0).

Source files
------------

// File: rtl/ro_meter_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
// The measurement FSM encoding and the synchronizer flush length live here.
package ro_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2,
    DONE = 2'd3
  } meter_state_e;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int ARM_CYCLES      = SYNC_STAGES_DEF + 1;

  // Flush time covers every synchronizer stage plus the edge-detect history flop.
  function automatic int arm_cycles(input int sync_stages);
    return sync_stages + 1;
  endfunction

endpackage

// File: rtl/ro_sync_edge.sv
// Brings the asynchronous oscillator into the clk domain and emits a
// one-cycle pulse for every rising edge seen at the end of the chain.
module ro_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // SYNC_STAGES must be at least 2, so the shift slice below is never empty.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: counts oscillator rising edges over a clk-timed gate.
// Define RO_METER_SAT_EN to saturate the edge counter; otherwise it wraps and flags overflow.
module ro_freq_meter
  import ro_meter_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              osc_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_cycles,
  output logic              ro_en,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [CNT_W-1:0]  result_count,
  output logic              overflow
);

  localparam int                ARM_LEN  = arm_cycles(SYNC_STAGES);
  localparam int                ARM_W    = $clog2(ARM_LEN + 1);
  localparam logic [ARM_W-1:0]  ARM_LOAD = ARM_W'(ARM_LEN - 1);
  localparam logic [ARM_W-1:0]  ARM_ONE  = ARM_W'(1);
  localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  meter_state_e      state_q, state_d;
  logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
  logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              osc_rise;

  ro_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (osc_in),
    .rise_o   (osc_rise)
  );

  // gate_cnt_q holds the latched gate length until GATE, then counts it down.
  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    arm_cnt_d  = arm_cnt_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ARM;
          gate_cnt_d = gate_cycles;
          arm_cnt_d  = ARM_LOAD;
          count_d    = '0;
          ovf_d      = 1'b0;
        end
      end
      ARM: begin
        if (arm_cnt_q == '0) begin
          state_d = (gate_cnt_q == '0) ? DONE : GATE;
        end else begin
          arm_cnt_d = arm_cnt_q - ARM_ONE;
        end
      end
      GATE: begin
        gate_cnt_d = gate_cnt_q - GATE_ONE;
        if (osc_rise) begin
`ifdef RO_METER_SAT_EN
          if (count_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + CNT_ONE;
          end
`else
          count_d = count_q + CNT_ONE;
          if (count_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end
`endif
        end
        if (gate_cnt_q == GATE_ONE) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      arm_cnt_q  <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      arm_cnt_q  <= arm_cnt_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  // Decoded straight from the state flop so the async reset drops ro_en immediately.
  assign ro_en        = (state_q != IDLE);
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign result_count = count_q;
  assign overflow     = ovf_q;

endmodule
